// File: rtl/offnariscv_pkg.sv
// Shared ACE constants, RRESP bit positions and the line-fill state type.
package offnariscv_pkg;

    // ACE channel field widths
    localparam int unsigned ACE_XID_WIDTH     = 4;
    localparam int unsigned ACE_XUSER_WIDTH   = 1;
    localparam int unsigned ACE_XLEN_WIDTH    = 8;
    localparam int unsigned ACE_XSIZE_WIDTH   = 3;
    localparam int unsigned ACE_XBURST_WIDTH  = 2;
    localparam int unsigned ACE_XCACHE_WIDTH  = 4;
    localparam int unsigned ACE_XPROT_WIDTH   = 3;
    localparam int unsigned ACE_XQOS_WIDTH    = 4;
    localparam int unsigned ACE_XREGION_WIDTH = 4;
    localparam int unsigned ACE_ARSNOOP_WIDTH = 4;
    localparam int unsigned ACE_XDOMAIN_WIDTH = 2;
    localparam int unsigned ACE_XBAR_WIDTH    = 2;
    localparam int unsigned ACE_RRESP_WIDTH   = 4;

    // AR channel encodings used by line fills
    localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READSHARED = 4'b0001;
    localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READUNIQUE = 4'b0111;
    localparam logic [ACE_XBURST_WIDTH-1:0]  AXBURST_INCR       = 2'b01;
    localparam logic [ACE_XDOMAIN_WIDTH-1:0] DOMAIN_INNER       = 2'b01;
    localparam logic [ACE_XCACHE_WIDTH-1:0]  ARCACHE_FILL       = 4'b0011;

    // RRESP bit indices
    localparam int unsigned RRESP_ISSHARED  = 3;
    localparam int unsigned RRESP_PASSDIRTY = 2;
    localparam int unsigned RRESP_ERR       = 1;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_AR,
        FILL_DATA,
        FILL_RSP
    } fill_state_e;

endpackage

// File: rtl/lsu_line_asm.sv
// Beat-indexed line register: each write replaces one bus-width slot.
module lsu_line_asm #(
    parameter int unsigned ACE_XDATA_WIDTH = 256,
    parameter int unsigned LINE_WIDTH      = 512,
    parameter int unsigned IDX_WIDTH       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [IDX_WIDTH-1:0]       idx,
    input  logic [ACE_XDATA_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0]      line
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    // Merge the incoming beat into its slot; other slots keep their contents
    always_comb begin
        line_d = line_q;
        if (we) begin
            line_d[int'(idx) * ACE_XDATA_WIDTH +: ACE_XDATA_WIDTH] = wdata;
        end
    end

    // Line storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/lsu_line_fill.sv
// ACE cache-line fill engine: one ReadShared/ReadUnique INCR burst per request,
// beats assembled into a full line returned with merged coherence/error status.
module lsu_line_fill
    import offnariscv_pkg::*;
#(
    parameter int unsigned ACE_XDATA_WIDTH  = 256,
    parameter int unsigned LINE_WIDTH       = 512,
    parameter int unsigned ACE_AXADDR_WIDTH = 32,
    parameter logic [ACE_XID_WIDTH-1:0] FILL_ID = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ACE_AXADDR_WIDTH-1:0]   req_addr,
    input  logic                          req_unique,
    output logic                          lsu_ace_arvalid,
    input  logic                          lsu_ace_arready,
    output logic [ACE_XID_WIDTH-1:0]      lsu_ace_arid,
    output logic [ACE_AXADDR_WIDTH-1:0]   lsu_ace_araddr,
    output logic [ACE_XLEN_WIDTH-1:0]     lsu_ace_arlen,
    output logic [ACE_XSIZE_WIDTH-1:0]    lsu_ace_arsize,
    output logic [ACE_XBURST_WIDTH-1:0]   lsu_ace_arburst,
    output logic                          lsu_ace_arlock,
    output logic [ACE_XCACHE_WIDTH-1:0]   lsu_ace_arcache,
    output logic [ACE_XPROT_WIDTH-1:0]    lsu_ace_arprot,
    output logic [ACE_XQOS_WIDTH-1:0]     lsu_ace_arqos,
    output logic [ACE_XREGION_WIDTH-1:0]  lsu_ace_arregion,
    output logic [ACE_XUSER_WIDTH-1:0]    lsu_ace_aruser,
    output logic [ACE_ARSNOOP_WIDTH-1:0]  lsu_ace_arsnoop,
    output logic [ACE_XDOMAIN_WIDTH-1:0]  lsu_ace_ardomain,
    output logic [ACE_XBAR_WIDTH-1:0]     lsu_ace_arbar,
    input  logic                          lsu_ace_rvalid,
    output logic                          lsu_ace_rready,
    input  logic [ACE_XID_WIDTH-1:0]      lsu_ace_rid,
    input  logic [ACE_XDATA_WIDTH-1:0]    lsu_ace_rdata,
    input  logic [ACE_RRESP_WIDTH-1:0]    lsu_ace_rresp,
    input  logic                          lsu_ace_rlast,
    input  logic [ACE_XUSER_WIDTH-1:0]    lsu_ace_ruser,
    output logic                          lsu_ace_rack,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [LINE_WIDTH-1:0]         rsp_line,
    output logic                          rsp_err,
    output logic                          rsp_shared,
    output logic                          rsp_dirty
);

    localparam int unsigned BEATS = LINE_WIDTH / ACE_XDATA_WIDTH;
    localparam int unsigned OFS   = $clog2(LINE_WIDTH / 8);
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0]             LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [ACE_XLEN_WIDTH-1:0]  ARLEN     = ACE_XLEN_WIDTH'(BEATS - 1);
    localparam logic [ACE_XSIZE_WIDTH-1:0] ARSIZE    = ACE_XSIZE_WIDTH'($clog2(ACE_XDATA_WIDTH / 8));

    fill_state_e                 state_q, state_d;
    logic                        req_ready_q, req_ready_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        rack_q, rack_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [ACE_AXADDR_WIDTH-1:0] addr_q, addr_d;
    logic                        unique_q, unique_d;
    logic [BCW-1:0]              beat_cnt_q, beat_cnt_d;
    logic                        err_q, err_d;
    logic                        shared_q, shared_d;
    logic                        dirty_q, dirty_d;

    logic                        r_hs;
    logic                        beat_last;
    logic                        beat_err;
    logic                        line_we;

    assign r_hs      = lsu_ace_rvalid && rready_q;
    assign beat_last = (beat_cnt_q == LAST_BEAT);
    // A burst whose rlast disagrees with the beat count is malformed either way
    assign beat_err  = lsu_ace_rresp[RRESP_ERR] || (lsu_ace_rid != FILL_ID)
                     || (lsu_ace_rlast != beat_last);

    // Next-state and next-output logic for the fill sequence
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rack_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        unique_d    = unique_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        shared_d    = shared_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = {req_addr[ACE_AXADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    unique_d    = req_unique;
                    req_ready_d = 1'b0;
                    arvalid_d   = 1'b1;
                    state_d     = FILL_AR;
                end
            end
            FILL_AR: begin
                if (lsu_ace_arready && arvalid_q) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    shared_d   = 1'b0;
                    dirty_d    = 1'b0;
                    state_d    = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (r_hs) begin
                    line_we  = 1'b1;
                    err_d    = err_q    || beat_err;
                    shared_d = shared_q || lsu_ace_rresp[RRESP_ISSHARED];
                    dirty_d  = dirty_q  || lsu_ace_rresp[RRESP_PASSDIRTY];
                    if (beat_last || lsu_ace_rlast) begin
                        rready_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rack_d      = 1'b1;
                        beat_cnt_d  = '0;
                        state_d     = FILL_RSP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            FILL_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = FILL_IDLE;
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL_IDLE;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            unique_q    <= 1'b0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rack_q      <= rack_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            unique_q    <= unique_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
        end
    end

    lsu_line_asm #(
        .ACE_XDATA_WIDTH (ACE_XDATA_WIDTH),
        .LINE_WIDTH      (LINE_WIDTH),
        .IDX_WIDTH       (BCW)
    ) u_line_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (line_we),
        .idx   (beat_cnt_q),
        .wdata (lsu_ace_rdata),
        .line  (rsp_line)
    );

    assign req_ready        = req_ready_q;
    assign lsu_ace_arvalid  = arvalid_q;
    assign lsu_ace_araddr   = addr_q;
    // Constant AR fields are qualified by arvalid so they read 0 outside a request
    assign lsu_ace_arid     = arvalid_q ? FILL_ID      : '0;
    assign lsu_ace_arlen    = arvalid_q ? ARLEN        : '0;
    assign lsu_ace_arsize   = arvalid_q ? ARSIZE       : '0;
    assign lsu_ace_arburst  = arvalid_q ? AXBURST_INCR : '0;
    assign lsu_ace_arcache  = arvalid_q ? ARCACHE_FILL : '0;
    assign lsu_ace_ardomain = arvalid_q ? DOMAIN_INNER : '0;
    assign lsu_ace_arsnoop  = !arvalid_q ? '0 :
                              (unique_q ? ARSNOOP_READUNIQUE : ARSNOOP_READSHARED);
    assign lsu_ace_arlock   = 1'b0;
    assign lsu_ace_arprot   = '0;
    assign lsu_ace_arqos    = '0;
    assign lsu_ace_arregion = '0;
    assign lsu_ace_aruser   = '0;
    assign lsu_ace_arbar    = '0;
    assign lsu_ace_rready   = rready_q;
    assign lsu_ace_rack     = rack_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_err          = err_q;
    assign rsp_shared       = shared_q;
    assign rsp_dirty        = dirty_q;

    logic unused_sigs;
    assign unused_sigs = ^{lsu_ace_ruser, lsu_ace_rresp[0], req_addr[OFS-1:0]};

endmodule

// File: tb/tb_lsu_line_fill.sv
// Directed bench for lsu_line_fill at LINE 512 / XDATA 256.
module tb_lsu_line_fill;
    import offnariscv_pkg::*;

    localparam int unsigned XW = 256;
    localparam int unsigned LW = 512;
    localparam int unsigned AW = 32;

    localparam logic [XW-1:0] DA = {8{32'hAAAA_AAAA}};
    localparam logic [XW-1:0] DB = {8{32'hBBBB_BBBB}};
    localparam logic [XW-1:0] D1 = {8{32'h1111_0000}};
    localparam logic [XW-1:0] D2 = {8{32'h2222_0000}};
    localparam logic [XW-1:0] D3 = {8{32'h3333_C0DE}};
    localparam logic [XW-1:0] D4 = {8{32'h4444_BEEF}};
    localparam logic [XW-1:0] D5 = {8{32'h5555_0001}};
    localparam logic [XW-1:0] D6 = {8{32'h6666_0002}};

    logic clk, rst_n;
    logic req_valid, req_ready, req_unique;
    logic [AW-1:0] req_addr;
    logic arvalid, arready, arlock;
    logic [3:0] arid, arcache, arqos, arregion, arsnoop;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, ardomain, arbar;
    logic [0:0] aruser, ruser;
    logic rvalid, rready, rlast, rack;
    logic [3:0] rid, rresp;
    logic [XW-1:0] rdata;
    logic rsp_valid, rsp_ready, rsp_err, rsp_shared, rsp_dirty;
    logic [LW-1:0] rsp_line;

    int vec;
    int miss;

    lsu_line_fill #(
        .ACE_XDATA_WIDTH  (XW),
        .LINE_WIDTH       (LW),
        .ACE_AXADDR_WIDTH (AW),
        .FILL_ID          (4'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_unique(req_unique),
        .lsu_ace_arvalid(arvalid), .lsu_ace_arready(arready), .lsu_ace_arid(arid),
        .lsu_ace_araddr(araddr), .lsu_ace_arlen(arlen), .lsu_ace_arsize(arsize),
        .lsu_ace_arburst(arburst), .lsu_ace_arlock(arlock), .lsu_ace_arcache(arcache),
        .lsu_ace_arprot(arprot), .lsu_ace_arqos(arqos), .lsu_ace_arregion(arregion),
        .lsu_ace_aruser(aruser), .lsu_ace_arsnoop(arsnoop), .lsu_ace_ardomain(ardomain),
        .lsu_ace_arbar(arbar),
        .lsu_ace_rvalid(rvalid), .lsu_ace_rready(rready), .lsu_ace_rid(rid),
        .lsu_ace_rdata(rdata), .lsu_ace_rresp(rresp), .lsu_ace_rlast(rlast),
        .lsu_ace_ruser(ruser), .lsu_ace_rack(rack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_line(rsp_line),
        .rsp_err(rsp_err), .rsp_shared(rsp_shared), .rsp_dirty(rsp_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [AW-1:0] a, input logic u);
        int n;
        req_addr = a; req_unique = u; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        vec++;
        if (!req_ready) begin miss++; $display("FAIL req_timeout: req_ready got 0 expected 1"); end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [XW-1:0] d, input logic [3:0] rs,
                             input logic l, input logic [3:0] id);
        int n;
        rvalid = 1'b1; rdata = d; rresp = rs; rlast = l; rid = id;
        n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        vec++;
        if (!rready) begin miss++; $display("FAIL rready_timeout: rready got 0 expected 1"); end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic finish_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        vec++;
        if (!rsp_valid) begin miss++; $display("FAIL rsp_timeout: rsp_valid got 0 expected 1"); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        vec++;
        if ({req_ready, arvalid, rready, rack, rsp_valid, rsp_err, rsp_shared, rsp_dirty} !== 8'h00) begin
            miss++; $display("FAIL reset_ctrl: got %b expected 00000000",
                {req_ready, arvalid, rready, rack, rsp_valid, rsp_err, rsp_shared, rsp_dirty});
        end
        vec++;
        if ({araddr, arlen, arsize, arsnoop, ardomain, arcache, arburst, arid} !== '0) begin
            miss++; $display("FAIL reset_ar: araddr %h arlen %h arsnoop %h expected all 0", araddr, arlen, arsnoop);
        end
        vec++;
        if (rsp_line !== '0) begin miss++; $display("FAIL reset_line: got %h expected 0", rsp_line); end
        rst_n = 1'b1;
        tick();
        vec++;
        if (req_ready !== 1'b1) begin miss++; $display("FAIL reset_release: req_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_read_shared();
        arready = 1'b1;
        send_req(32'h0000_1234, 1'b0);
        vec++;
        if (arvalid !== 1'b1 || rready !== 1'b0) begin
            miss++; $display("FAIL rs_arvalid: arvalid %b rready %b expected 1 0", arvalid, rready);
        end
        vec++;
        if (araddr !== 32'h0000_1200) begin miss++; $display("FAIL rs_araddr: got %h expected 00001200", araddr); end
        vec++;
        if ({arlen, arsize, arsnoop, ardomain, arcache, arburst, arid, arbar} !== {8'd1, 3'd5, 4'b0001, 2'b01, 4'b0011, 2'b01, 4'd0, 2'b00}) begin
            miss++; $display("FAIL rs_arfields: arlen %h arsize %h arsnoop %b ardomain %b arcache %b arburst %b expected 1 5 0001 01 0011 01",
                arlen, arsize, arsnoop, ardomain, arcache, arburst);
        end
        tick();
        vec++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            miss++; $display("FAIL rs_rready: arvalid %b rready %b expected 0 1", arvalid, rready);
        end
        send_beat(DA, 4'b0000, 1'b0, 4'd0);
        vec++;
        if (rsp_valid !== 1'b0) begin miss++; $display("FAIL rs_midburst: rsp_valid got %b expected 0", rsp_valid); end
        send_beat(DB, 4'b0000, 1'b1, 4'd0);
        vec++;
        if (rsp_valid !== 1'b1 || rack !== 1'b1 || rready !== 1'b0) begin
            miss++; $display("FAIL rs_done: rsp_valid %b rack %b rready %b expected 1 1 0", rsp_valid, rack, rready);
        end
        vec++;
        if (rsp_line !== {DB, DA}) begin miss++; $display("FAIL rs_line: got %h expected %h", rsp_line, {DB, DA}); end
        vec++;
        if ({rsp_err, rsp_shared, rsp_dirty} !== 3'b000) begin
            miss++; $display("FAIL rs_status: got %b expected 000", {rsp_err, rsp_shared, rsp_dirty});
        end
        tick();
        vec++;
        if (rack !== 1'b0 || rsp_valid !== 1'b1) begin
            miss++; $display("FAIL rs_rack_pulse: rack %b rsp_valid %b expected 0 1", rack, rsp_valid);
        end
        finish_rsp();
        vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miss++; $display("FAIL rs_return: req_ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_read_unique();
        arready = 1'b1;
        send_req(32'h0000_8040, 1'b1);
        vec++;
        if (arsnoop !== 4'b0111 || araddr !== 32'h0000_8040) begin
            miss++; $display("FAIL ru_ar: arsnoop %b araddr %h expected 0111 00008040", arsnoop, araddr);
        end
        tick();
        send_beat(D1, 4'b1000, 1'b0, 4'd0);
        send_beat(D2, 4'b0100, 1'b1, 4'd0);
        vec++;
        if ({rsp_valid, rsp_err, rsp_shared, rsp_dirty} !== 4'b1011) begin
            miss++; $display("FAIL ru_status: valid/err/shared/dirty got %b expected 1011",
                {rsp_valid, rsp_err, rsp_shared, rsp_dirty});
        end
        vec++;
        if (rsp_line !== {D2, D1}) begin miss++; $display("FAIL ru_line: got %h expected %h", rsp_line, {D2, D1}); end
        finish_rsp();
    endtask

    task automatic test_arready_delay();
        arready = 1'b0;
        send_req(32'h0000_ABCD, 1'b0);
        rvalid = 1'b1; rdata = D3; rresp = 4'b0000; rlast = 1'b0; rid = 4'd0;
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (arvalid !== 1'b1 || araddr !== 32'h0000_ABC0 || arsnoop !== 4'b0001 || arlen !== 8'd1 || rready !== 1'b0) begin
                miss++; $display("FAIL ard_hold%0d: arvalid %b araddr %h arsnoop %b arlen %h rready %b expected 1 0000abc0 0001 01 0",
                    i, arvalid, araddr, arsnoop, arlen, rready);
            end
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        vec++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            miss++; $display("FAIL ard_enter: rready %b arvalid %b expected 1 0", rready, arvalid);
        end
        tick();
        rdata = D4; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_line !== {D4, D3} || rsp_err !== 1'b0) begin
            miss++; $display("FAIL ard_line: valid %b err %b line %h expected 1 0 %h", rsp_valid, rsp_err, rsp_line, {D4, D3});
        end
        finish_rsp();
    endtask

    task automatic test_bad_bursts();
        arready = 1'b1;
        send_req(32'h0000_0080, 1'b0);
        tick();
        send_beat(D5, 4'b0000, 1'b1, 4'd0);
        vec++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rack !== 1'b1) begin
            miss++; $display("FAIL early_rlast: valid %b err %b rack %b expected 1 1 1", rsp_valid, rsp_err, rack);
        end
        vec++;
        if (rsp_line !== {D4, D5}) begin miss++; $display("FAIL early_line: got %h expected %h", rsp_line, {D4, D5}); end
        finish_rsp();
        send_req(32'h0000_00C0, 1'b0);
        tick();
        send_beat(D1, 4'b0000, 1'b0, 4'd3);
        send_beat(D2, 4'b0000, 1'b1, 4'd0);
        vec++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            miss++; $display("FAIL bad_rid: valid %b err %b expected 1 1", rsp_valid, rsp_err);
        end
        finish_rsp();
        send_req(32'h0000_0100, 1'b0);
        tick();
        send_beat(D1, 4'b0010, 1'b0, 4'd0);
        send_beat(D2, 4'b0000, 1'b1, 4'd0);
        vec++;
        if (rsp_err !== 1'b1) begin miss++; $display("FAIL slverr: err got %b expected 1", rsp_err); end
        finish_rsp();
    endtask

    task automatic test_rsp_stall();
        arready = 1'b1;
        send_req(32'h0000_0200, 1'b0);
        tick();
        send_beat(D3, 4'b0000, 1'b0, 4'd0);
        send_beat(D6, 4'b0000, 1'b1, 4'd0);
        req_valid = 1'b1; req_addr = 32'h0000_0400; req_unique = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || arvalid !== 1'b0 || rsp_line !== {D6, D3} || rsp_err !== 1'b0) begin
                miss++; $display("FAIL stall%0d: req_ready %b rsp_valid %b arvalid %b err %b expected 0 1 0 0",
                    i, req_ready, rsp_valid, arvalid, rsp_err);
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || arvalid !== 1'b0) begin
            miss++; $display("FAIL stall_release: req_ready %b rsp_valid %b arvalid %b expected 1 0 0", req_ready, rsp_valid, arvalid);
        end
    endtask

    task automatic test_reset_mid();
        arready = 1'b1;
        send_req(32'h0000_0300, 1'b1);
        tick();
        send_beat(D1, 4'b1100, 1'b0, 4'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec++;
        if ({req_ready, arvalid, rready, rack, rsp_valid, rsp_err, rsp_shared, rsp_dirty} !== 8'h00) begin
            miss++; $display("FAIL midrst_ctrl: got %b expected 00000000",
                {req_ready, arvalid, rready, rack, rsp_valid, rsp_err, rsp_shared, rsp_dirty});
        end
        vec++;
        if (araddr !== '0 || arsnoop !== '0 || rsp_line !== '0) begin
            miss++; $display("FAIL midrst_data: araddr %h arsnoop %b line %h expected 0", araddr, arsnoop, rsp_line);
        end
        send_req(32'h0000_0040, 1'b0);
        tick();
        send_beat(D5, 4'b0000, 1'b0, 4'd0);
        send_beat(D6, 4'b0000, 1'b1, 4'd0);
        vec++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_line !== {D6, D5}) begin
            miss++; $display("FAIL midrst_refill: valid %b err %b line %h expected 1 0 %h", rsp_valid, rsp_err, rsp_line, {D6, D5});
        end
        finish_rsp();
    endtask

    initial begin
        vec = 0; miss = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_unique = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        ruser = '0; rsp_ready = 1'b0;
        test_reset();
        test_read_shared();
        test_read_unique();
        test_arready_delay();
        test_bad_bursts();
        test_rsp_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
